// File: rtl/pe_pkg.sv
// Shared definitions for the pe_top SIMD processing element: lane geometry,
// memory depths, opcode encoding, instruction field positions, FSM codes.
package pe_pkg;

    localparam int LANES      = 4;
    localparam int WORD_W     = 32;
    localparam int DATA_DEPTH = 16;
    localparam int INST_DEPTH = 256;
    localparam int DADDR_W    = 4;
    localparam int PC_W       = 8;

    // One RAM word: four 32-bit lanes, lane 0 in bits [31:0].
    typedef logic [LANES-1:0][WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_CLR  = 4'h1,
        OP_MAC  = 4'h2,
        OP_STR  = 4'h3,
        OP_HALT = 4'hF
    } opcode_e;

    // Instruction field positions; the lane field overlaps the low bits of r_addr.
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int A_MSB    = 27;
    localparam int A_LSB    = 24;
    localparam int B_MSB    = 23;
    localparam int B_LSB    = 20;
    localparam int R_MSB    = 19;
    localparam int R_LSB    = 16;
    localparam int LANE_MSB = 17;
    localparam int LANE_LSB = 16;

    // Sequencer state codes.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/pe_mem_unit.sv
// Storage for the processing element: operand RAMs A and B, the result RAM
// and the instruction RAM. Reads are asynchronous; writes are synchronous.
// None of the arrays are reset, so contents survive rstn. The ld_* port is a
// host preload path (word written into A, B, or lane 0 into the program RAM).
import pe_pkg::*;

module pe_mem_unit (
    input  logic               clk,
    input  logic               ld_en,
    input  logic [1:0]         ld_sel,
    input  logic [PC_W-1:0]    ld_addr,
    input  word_t              ld_data,
    input  logic [PC_W-1:0]    inst_addr,
    output logic [31:0]        inst_data,
    input  logic [DADDR_W-1:0] a_addr,
    output word_t              a_data,
    input  logic [DADDR_W-1:0] b_addr,
    output word_t              b_data,
    input  logic               res_we,
    input  logic [DADDR_W-1:0] res_addr,
    input  word_t              res_data
);

    word_t       ram_a      [DATA_DEPTH];
    word_t       ram_b      [DATA_DEPTH];
    word_t       ram_result [DATA_DEPTH];
    logic [31:0] ram_inst   [INST_DEPTH];

    // Host preload of operands and program (ld_sel: 0 = A, 1 = B, 2 = program).
    always_ff @(posedge clk) begin
        if (ld_en) begin
            case (ld_sel)
                2'd0:    ram_a[ld_addr[DADDR_W-1:0]] <= ld_data;
                2'd1:    ram_b[ld_addr[DADDR_W-1:0]] <= ld_data;
                2'd2:    ram_inst[ld_addr]           <= ld_data[0];
                default: ;
            endcase
        end
    end

    // Result write port driven by STR.
    always_ff @(posedge clk) begin
        if (res_we) begin
            ram_result[res_addr] <= res_data;
        end
    end

    assign inst_data = ram_inst[inst_addr];
    assign a_data    = ram_a[a_addr];
    assign b_data    = ram_b[b_addr];

endmodule

// File: rtl/pe_top.sv
// SIMD processing element: sequences a stored program of 4-lane vector
// instructions (CLR / MAC / STR / HALT) over the RAMs in fetch_unit.
// Each instruction takes two cycles (FETCH then EXEC).
// Handshake: valid is a one-cycle start pulse, accepted only in IDLE or DONE
// and ignored while a program runs; stop is a level that rises when HALT
// executes and stays high until the next accepted valid.
// Optional build macro PE_CYCLE_COUNT_EN adds a 32-bit cycle_count register.
import pe_pkg::*;

module pe_top (
    input  logic clk,
    input  logic rstn,
    input  logic valid,
    output logic stop
);

    logic [1:0]        state;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [WORD_W-1:0] acc [LANES];

    logic [31:0]        inst_data;
    word_t              a_data;
    word_t              b_data;
    word_t              res_data;
    logic               res_we;
    opcode_e            op;
    logic [1:0]         lane;
    logic [WORD_W-1:0]  prod [LANES];
    logic [WORD_W-1:0]  dot;
    logic               start;
    logic               last_inst;
    logic               unused_ir_bits;

    assign op        = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign lane      = ir[LANE_MSB:LANE_LSB];
    assign start     = ((state == ST_IDLE) || (state == ST_DONE)) && valid;
    assign last_inst = (pc == PC_W'(INST_DEPTH - 1));
    assign unused_ir_bits = ^ir[15:0];

    pe_mem_unit fetch_unit (
        .clk       (clk),
        .ld_en     (1'b0),
        .ld_sel    (2'd0),
        .ld_addr   ('0),
        .ld_data   ('0),
        .inst_addr (pc),
        .inst_data (inst_data),
        .a_addr    (ir[A_MSB:A_LSB]),
        .a_data    (a_data),
        .b_addr    (ir[B_MSB:B_LSB]),
        .b_data    (b_data),
        .res_we    (res_we),
        .res_addr  (ir[R_MSB:R_LSB]),
        .res_data  (res_data)
    );

    // Four lane multipliers feeding a two-level adder tree, all modulo 2^32.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod[k] = a_data[k] * b_data[k];
        end
        dot = (prod[0] + prod[1]) + (prod[2] + prod[3]);
    end

    // STR writes acc0 into the most significant lane of the result word.
    assign res_data = {acc[0], acc[1], acc[2], acc[3]};
    assign res_we   = (state == ST_EXEC) && (op == OP_STR);

    // Sequencer: program counter, instruction register, accumulators, stop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            stop  <= 1'b0;
            for (int k = 0; k < LANES; k++) acc[k] <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (valid) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                        stop  <= 1'b0;
                        for (int k = 0; k < LANES; k++) acc[k] <= '0;
                    end
                end
                ST_FETCH: begin
                    ir    <= inst_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (op)
                        OP_CLR:  for (int k = 0; k < LANES; k++) acc[k] <= '0;
                        OP_MAC:  acc[lane] <= acc[lane] + dot;
                        default: ;
                    endcase
                    // The last program slot always terminates; pc never wraps.
                    if ((op == OP_HALT) || last_inst) begin
                        state <= ST_DONE;
                        stop  <= 1'b1;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PE_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    // Counts busy cycles of the current run; holds its value in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_count <= '0;
        end else if (start) begin
            cycle_count <= '0;
        end else if ((state == ST_FETCH) || (state == ST_EXEC)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_top.sv
// Directed bench for pe_top: loads operands and programs into fetch_unit,
// pulses valid, waits for stop and compares results with hand-derived values.
import pe_pkg::*;

module tb_pe_top;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid = 1'b0;
    logic stop;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [31:0] mat_a [8][8];
    logic [31:0] mat_b [8][8];
    word_t       snap  [16];

    always #5 clk = ~clk;

    pe_top dut (
        .clk   (clk),
        .rstn  (rstn),
        .valid (valid),
        .stop  (stop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_ab();
        for (int i = 0; i < 8; i++)
            for (int h = 0; h < 2; h++)
                for (int k = 0; k < 4; k++) begin
                    dut.fetch_unit.ram_a[2*i+h][k] = mat_a[i][4*h+k];
                    dut.fetch_unit.ram_b[2*i+h][k] = mat_b[i][4*h+k];
                end
    endtask

    task automatic load_std();
        int n;
        n = 0;
        for (int w = 0; w < 16; w++) begin
            int i, h;
            i = w / 2;
            h = w % 2;
            dut.fetch_unit.ram_inst[n] = {4'h1, 28'h0}; n++;
            for (int l = 0; l < 4; l++) begin
                int j;
                j = 4 * h + l;
                dut.fetch_unit.ram_inst[n] = {4'h2, 4'(2*i), 4'(2*j), 2'b00, 2'(l), 16'h0}; n++;
                dut.fetch_unit.ram_inst[n] = {4'h2, 4'(2*i+1), 4'(2*j+1), 2'b00, 2'(l), 16'h0}; n++;
            end
            dut.fetch_unit.ram_inst[n] = {4'h3, 8'h0, 4'(w), 16'h0}; n++;
        end
        dut.fetch_unit.ram_inst[n] = {4'hF, 28'h0};
        for (int p = n + 1; p < 256; p++) dut.fetch_unit.ram_inst[p] = 32'h0;
    endtask

    // Pulse valid, then count cycles until stop; poke_at >= 0 re-pulses valid mid-run.
    task automatic run(input int poke_at, output int c);
        @(negedge clk); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        c = 0;
        while (!stop && c < 2000) begin
            if (c == poke_at) valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            c++;
        end
    endtask

    function automatic logic [31:0] c_elem(input int i, input int j);
        word_t w;
        w = dut.fetch_unit.ram_result[2*i + j/4];
        return w[3 - (j % 4)];
    endfunction

    task automatic take_snap();
        for (int w = 0; w < 16; w++) snap[w] = dut.fetch_unit.ram_result[w];
    endtask

    task automatic check_snap(input string tag);
        for (int w = 0; w < 16; w++)
            check($sformatf("%s_w%0d", tag, w),
                  {31'b0, dut.fetch_unit.ram_result[w] === snap[w]}, 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_stop", {31'b0, stop}, 32'd0);
        check("rst_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        check("rst_pc", {24'b0, dut.pc}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // All-ones operands: every element is 8
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin mat_a[i][k] = 32'd1; mat_b[i][k] = 32'd1; end
        load_ab();
        load_std();
        run(-1, cyc);
        check("ones_cycles", cyc, 32'd322);
        check("ones_stop", {31'b0, stop}, 32'd1);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                check($sformatf("ones_c%0d%0d", i, j), c_elem(i, j), 32'd8);

        // Identity A, random B: C = B transposed; valid poked mid-run must be ignored
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                mat_a[i][k] = (i == k) ? 32'd1 : 32'd0;
                mat_b[i][k] = $urandom;
            end
        load_ab();
        run(101, cyc);
        check("ident_cycles", cyc, 32'd322);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                check($sformatf("ident_c%0d%0d", i, j), c_elem(i, j), mat_b[j][i]);

        // Modulo wrap: 8 * (0xFFFFFFFF * 2) mod 2^32
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin mat_a[i][k] = 32'hFFFF_FFFF; mat_b[i][k] = 32'd2; end
        load_ab();
        run(-1, cyc);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                check($sformatf("wrap_c%0d%0d", i, j), c_elem(i, j), 32'hFFFF_FFF0);

        // HALT-only program
        take_snap();
        dut.fetch_unit.ram_inst[0] = {4'hF, 28'h0};
        run(-1, cyc);
        check("halt_cycles", cyc, 32'd2);
`ifdef PE_CYCLE_COUNT_EN
        check("halt_cycle_count", dut.cycle_count, 32'd2);
`endif
        check_snap("halt_unchanged");
        repeat (3) @(negedge clk);
        check("halt_stop_held", {31'b0, stop}, 32'd1);
        @(negedge clk); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        check("restart_stop_low", {31'b0, stop}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("restart_stop_high", {31'b0, stop}, 32'd1);

        // Asynchronous reset mid-program, then full rerun
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                mat_a[i][k] = $urandom_range(0, 1000);
                mat_b[i][k] = $urandom;
            end
        load_ab();
        load_std();
        @(negedge clk); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        repeat (57) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_stop", {31'b0, stop}, 32'd0);
        check("mid_rst_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        check("mid_rst_pc", {24'b0, dut.pc}, 32'd0);
        for (int k = 0; k < 4; k++)
            check($sformatf("mid_rst_acc%0d", k), dut.acc[k], 32'd0);
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", {30'b0, dut.state}, {30'b0, ST_IDLE});
        run(-1, cyc);
        check("rerun_cycles", cyc, 32'd322);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                logic [31:0] s;
                s = 32'd0;
                for (int k = 0; k < 8; k++) s = s + mat_a[i][k] * mat_b[j][k];
                check($sformatf("rerun_c%0d%0d", i, j), c_elem(i, j), s);
            end

        // Unknown opcode 0x7 (r field 5) executes as NOP, then HALT
        take_snap();
        dut.fetch_unit.ram_inst[0] = 32'h7005_0000;
        dut.fetch_unit.ram_inst[1] = {4'hF, 28'h0};
        run(-1, cyc);
        check("unk_cycles", cyc, 32'd4);
        check("unk_w5", {31'b0, dut.fetch_unit.ram_result[5] === snap[5]}, 32'd1);

        // No HALT anywhere: the last slot terminates the program
        for (int p = 0; p < 256; p++)
            dut.fetch_unit.ram_inst[p] = (p % 3 == 0) ? {4'(4 + p % 11), 28'h0} : 32'h0;
        run(-1, cyc);
        check("nohalt_cycles", cyc, 32'd512);
        check("nohalt_stop", {31'b0, stop}, 32'd1);
        check("nohalt_pc", {24'b0, dut.pc}, 32'd255);
        check_snap("nohalt_unchanged");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
